// File: rtl/core_dispatch_scheduler.sv
// Round-robin job dispatcher for the input-stream scanner: grants one core per
// streamed job, tracks per-core busy/ownership, and flags stalled transfers.
module core_dispatch_scheduler #(
  parameter int M_COUNT        = 8,
  parameter int JOB_ID_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [JOB_ID_WIDTH-1:0]           job_id,
  input  logic [M_COUNT-1:0]                core_idle,
  input  logic [M_COUNT-1:0]                core_done,
  input  logic                              xfer_beat,
  input  logic                              xfer_last,
  output logic [M_COUNT-1:0]                access_core,
  output logic [M_COUNT-1:0]                core_busy,
  output logic [M_COUNT*JOB_ID_WIDTH-1:0]   core_job_id,
  output logic [$clog2(M_COUNT+1)-1:0]      busy_count,
  output logic                              dispatch_done,
  output logic [$clog2(M_COUNT)-1:0]        dispatch_core,
  output logic                              timeout_err,
  input  logic                              err_clear,
  output logic [1:0]                        dbg_state_o
);

  localparam int IDX_W = $clog2(M_COUNT);
  localparam int CNT_W = $clog2(M_COUNT+1);
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Handshake: job_ready is a combinational strobe, high only in IDLE in the
  // cycle job_valid is seen with an eligible core; the job is taken that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [M_COUNT-1:0]                grant_q, grant_d;
  logic [IDX_W-1:0]                  grant_idx_q, grant_idx_d;
  logic [JOB_ID_WIDTH-1:0]           tag_q, tag_d;
  logic [M_COUNT-1:0]                access_q, access_d;
  logic [M_COUNT-1:0]                busy_q, busy_d;
  logic [M_COUNT*JOB_ID_WIDTH-1:0]   job_id_q;
  logic [CNT_W-1:0]                  busy_count_q, busy_count_d;
  logic                              done_q, done_d;
  logic [IDX_W-1:0]                  dcore_q, dcore_d;
  logic                              err_q, err_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic [DRN_W-1:0]                  drain_q, drain_d;

  logic [M_COUNT-1:0]                eligible;
  logic                              pick_valid;
  logic [IDX_W-1:0]                  pick_idx;
  logic [IDX_W:0]                    probe;
  logic [M_COUNT-1:0]                set_busy;
  logic                              tmo_set;

  assign eligible = core_idle & ~busy_q;

  // First eligible core at or after rr_ptr, wrapping modulo M_COUNT.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    probe      = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      probe = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (probe >= (IDX_W+1)'(M_COUNT)) probe = probe - (IDX_W+1)'(M_COUNT);
      if (!pick_valid && eligible[probe[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = probe[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    tag_d       = tag_q;
    access_d    = access_q;
    tmo_d       = tmo_q;
    drain_d     = drain_q;
    dcore_d     = dcore_q;
    done_d      = 1'b0;
    set_busy    = '0;
    tmo_set     = 1'b0;
    job_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid && pick_valid) begin
          job_ready   = 1'b1;
          grant_d     = {{(M_COUNT-1){1'b0}}, 1'b1} << pick_idx;
          access_d    = {{(M_COUNT-1){1'b0}}, 1'b1} << pick_idx;
          grant_idx_d = pick_idx;
          tag_d       = job_id;
          rr_ptr_d    = (pick_idx == IDX_W'(M_COUNT-1)) ? '0 : pick_idx + IDX_W'(1);
          tmo_d       = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (xfer_beat) begin
          if (xfer_last) begin
            set_busy = grant_q;
            done_d   = 1'b1;
            dcore_d  = grant_idx_q;
            access_d = '0;
            drain_d  = '0;
            state_d  = DRAIN;
          end else begin
            tmo_d = '0;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES-1)) begin
          // Stalled: abandon the job without claiming the core.
          tmo_set  = 1'b1;
          access_d = '0;
          drain_d  = '0;
          state_d  = DRAIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(DRAIN_CYCLES-1)) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new claim beats a completion for the same core in the same cycle.
  assign busy_d = (busy_q & ~core_done) | set_busy;
  assign err_d  = (err_q & ~err_clear) | tmo_set;

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < M_COUNT; i++) busy_count_d = busy_count_d + CNT_W'(busy_q[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      tag_q        <= '0;
      access_q     <= '0;
      busy_q       <= '0;
      job_id_q     <= '0;
      busy_count_q <= '0;
      done_q       <= 1'b0;
      dcore_q      <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      tag_q        <= tag_d;
      access_q     <= access_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      done_q       <= done_d;
      dcore_q      <= dcore_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      drain_q      <= drain_d;
      for (int i = 0; i < M_COUNT; i++) begin
        if (set_busy[i]) job_id_q[i*JOB_ID_WIDTH +: JOB_ID_WIDTH] <= tag_q;
      end
    end
  end

  assign access_core   = access_q;
  assign core_busy     = busy_q;
  assign core_job_id   = job_id_q;
  assign busy_count    = busy_count_q;
  assign dispatch_done = done_q;
  assign dispatch_core = dcore_q;
  assign timeout_err   = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/core_dispatch_scheduler.md
Name: core_dispatch_scheduler

Overview:
- Sequences the input-stream scanner. Accepts job requests from the host side and picks an eligible core by round-robin.
- Drives the scanner's one-hot `access_core` select for the duration of one streamed job, then inserts a drain gap.
- Tracks per-core busy state and job ownership until each core reports completion. Flags stalled transfers with a timeout.

Parameters:
- M_COUNT, 8, number of cores; matches the scanner's core count.
- JOB_ID_WIDTH, 8, width of the host job tag.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between accepted stream beats in XFER.
- DRAIN_CYCLES, 3, cycles `access_core` is held at zero after a job, so the scanner returns to its scan state. Must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  host has a job to dispatch.
- job_ready  out  1  one-cycle accept strobe for the job.
- job_id  in  JOB_ID_WIDTH  tag of the offered job.
- core_idle  in  M_COUNT  core i can take a new job.
- core_done  in  M_COUNT  one-cycle pulse, core i finished its job.
- xfer_beat  in  1  stream beat accepted at the scanner input (s_valid & s_ready).
- xfer_last  in  1  s_last qualifier for xfer_beat.
- access_core  out  M_COUNT  one-hot core select to the scanner; zero when no grant.
- core_busy  out  M_COUNT  core holds an undispatched-complete job.
- core_job_id  out  M_COUNT*JOB_ID_WIDTH  job tag owned by each core; slice i = bits [i*JOB_ID_WIDTH +: JOB_ID_WIDTH].
- busy_count  out  $clog2(M_COUNT+1)  popcount of core_busy.
- dispatch_done  out  1  one-cycle pulse when a job's last beat is accepted.
- dispatch_core  out  $clog2(M_COUNT)  index of the core for dispatch_done; held until the next dispatch.
- timeout_err  out  1  sticky stall flag.
- err_clear  in  1  clears timeout_err.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE; rr_ptr = 0; grant = 0.
  - access_core, core_busy, core_job_id = 0; busy_count = 0.
  - job_ready, dispatch_done, dispatch_core, timeout_err = 0.
  - timeout and drain counters = 0.
  - Reset mid-transfer abandons the job without marking busy.
- eligible = core_idle & ~core_busy.
- Round-robin pick: the first set bit of eligible searching from rr_ptr upward, wrapping modulo M_COUNT. This logic is combinational.
- IDLE:
  - If job_valid && eligible != 0: assert job_ready for exactly this cycle, register grant = one-hot(pick), latch job_id, set rr_ptr = (pick+1) mod M_COUNT, clear the timeout counter, go to XFER.
  - Otherwise job_ready = 0 and stay in IDLE.
  - job_ready is never asserted outside IDLE.
- XFER:
  - access_core = grant (registered, glitch-free); it is zero in all other states.
  - xfer_beat && !xfer_last: clear the timeout counter.
  - xfer_beat && xfer_last: set core_busy[grant], write the latched tag into core_job_id slice, pulse dispatch_done, update dispatch_core, go to DRAIN.
  - No beat: increment the timeout counter. When the count reaches TIMEOUT_CYCLES-1, set timeout_err, do not mark busy, and go to DRAIN.
- DRAIN:
  - access_core = 0 for exactly DRAIN_CYCLES cycles, then go to IDLE and clear grant.
  - xfer_beat during DRAIN or IDLE is ignored.
- Busy clear: core_done[i] clears core_busy[i]; core_job_id slice i keeps its value.
  - core_done for a non-busy core is ignored.
  - If core_done[i] and the busy set for the same core i occur in the same cycle, set wins.
  - Multiple core_done bits in one cycle are all honoured.
- busy_count is registered and equals popcount(core_busy) with one cycle of latency relative to core_busy.
- timeout_err: err_clear clears it. If set and clear occur in the same cycle, set wins.
- Minimum job-to-job spacing is 1 (accept) + beats + DRAIN_CYCLES cycles.
- If all cores are busy or not idle, job_valid waits indefinitely; there is no timeout in IDLE.

Test Plan:
- Round-robin rotation: M_COUNT=8, all core_idle=1, four back-to-back 3-beat jobs with ids 0x10..0x13.
  - access_core = 0x01, 0x02, 0x04, 0x08.
  - core_busy = 0x0F; core_job_id slices 0..3 = 0x10..0x13; busy_count = 4.
- Skip ineligible cores: core_busy=0x0F, core_idle=0xF7, rr_ptr=3, job offered.
  - Grant core 4 (access_core = 0x10); rr_ptr becomes 5.
- Completion and same-cycle collision:
  - core_done=0x05 while busy=0x0F gives busy=0x0A.
  - core_done[2] pulsed in the same cycle as a last beat to core 2 leaves busy[2]=1.
- Timeout: grant issued with no xfer_beat for 1024 cycles.
  - timeout_err=1 at cycle 1024 after entering XFER; busy not set; access_core returns to 0; state returns to IDLE after 3 cycles.
  - err_clear then gives timeout_err=0.
- Drain gap: a new job_valid held high during DRAIN.
  - job_ready stays 0 for DRAIN_CYCLES cycles after dispatch_done.
  - The next access_core goes non-zero one cycle after job_ready.
- Reset mid-XFER after 2 of 4 beats: reset pulsed.
  - All outputs are 0 asynchronously; the next job is granted to core 0.
